// File: rtl/cga_tty.sv
// cga_tty: text-console writer for the 80x25 CGA text videoram.
// Accepts ASCII bytes over valid/ready and writes character/attribute pairs
// (even byte = character, odd byte = attribute). Handles CR, LF, BS and FF,
// wraps at end of line and scrolls the screen up one row at the bottom.
// Optional feature macro: CGA_TTY_TAB_EN (0x09 moves to the next tab stop
// instead of being printed as a glyph).
module cga_tty #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 25,
    parameter logic [7:0] FILL_ATTR = 8'h07
) (
    input  logic        clock_25,
    input  logic        reset_n,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    input  logic [7:0]  char_attr,
    output logic        char_ready,
    output logic [11:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [10:0] cursor,
    output logic        busy
);

    typedef enum logic [2:0] {
        CLEAR, IDLE, WR_CHAR, WR_ATTR, CTRL, SCROLL_RD, SCROLL_WR, SCROLL_FILL
    } state_t;

    localparam logic [11:0] ROW_BYTES  = 12'(2 * COLS);
    localparam logic [11:0] LAST_ADDR  = 12'(2 * COLS * ROWS - 1);
    localparam logic [11:0] FILL_START = 12'(2 * COLS * (ROWS - 1));
    localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [10:0] cursor_q, cursor_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  attr_q, attr_d;
    logic        go_idle, go_scroll;
    logic        is_ctrl;

    // Blank cell content: space on character bytes, fill attribute on odd bytes.
    function automatic logic [7:0] blank_byte(input logic odd);
        return odd ? FILL_ATTR : 8'h20;
    endfunction

`ifdef CGA_TTY_TAB_EN
    logic [7:0] tab_col;
    assign tab_col = {1'b0, col_q[6:3], 3'b000} + 8'd8;
    assign is_ctrl = (char_data == 8'h0D) || (char_data == 8'h0A) ||
                     (char_data == 8'h08) || (char_data == 8'h09);
`else
    assign is_ctrl = (char_data == 8'h0D) || (char_data == 8'h0A) ||
                     (char_data == 8'h08);
`endif

    // Next-state logic; memory outputs are registered, so each branch sets up
    // the bus values for the cycle that follows the edge.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        char_d    = char_q;
        attr_d    = attr_q;
        go_idle   = 1'b0;
        go_scroll = 1'b0;

        case (state_q)
            CLEAR: begin
                we_d = 1'b1;
                if (!we_q) begin
                    addr_d = 12'd0;              // first write after reset
                end else if (addr_q == LAST_ADDR) begin
                    we_d    = 1'b0;
                    go_idle = 1'b1;
                end else begin
                    addr_d = addr_q + 12'd1;
                end
                wdata_d = blank_byte(addr_d[0]);
            end
            IDLE: begin
                if (char_valid) begin
                    char_d = char_data;
                    attr_d = char_attr;
                    if (char_data == 8'h0C) begin
                        col_d   = 7'd0;
                        row_d   = 5'd0;
                        state_d = CLEAR;
                        we_d    = 1'b1;
                        addr_d  = 12'd0;
                        wdata_d = 8'h20;
                    end else if (is_ctrl) begin
                        state_d = CTRL;
                    end else begin
                        state_d = WR_CHAR;
                        we_d    = 1'b1;
                        addr_d  = {cursor_q, 1'b0};
                        wdata_d = char_data;
                    end
                end
            end
            WR_CHAR: begin
                state_d = WR_ATTR;
                we_d    = 1'b1;
                addr_d  = addr_q + 12'd1;
                wdata_d = attr_q;
            end
            WR_ATTR: begin
                go_idle = 1'b1;
                if (col_q == LAST_COL) begin
                    col_d = 7'd0;
                    if (row_q == LAST_ROW) go_scroll = 1'b1;
                    else                   row_d = row_q + 5'd1;
                end else begin
                    col_d = col_q + 7'd1;
                end
            end
            CTRL: begin
                go_idle = 1'b1;
                case (char_q)
                    8'h0D: col_d = 7'd0;
                    8'h0A: begin
                        if (row_q == LAST_ROW) go_scroll = 1'b1;
                        else                   row_d = row_q + 5'd1;
                    end
                    8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
`ifdef CGA_TTY_TAB_EN
                    8'h09: begin
                        if (tab_col >= 8'(COLS)) begin
                            col_d = 7'd0;
                            if (row_q == LAST_ROW) go_scroll = 1'b1;
                            else                   row_d = row_q + 5'd1;
                        end else begin
                            col_d = tab_col[6:0];
                        end
                    end
`endif
                    default: ;
                endcase
            end
            SCROLL_RD: begin
                // Read data arrives next cycle; write it one row higher.
                state_d = SCROLL_WR;
                we_d    = 1'b1;
                addr_d  = addr_q - ROW_BYTES;
            end
            SCROLL_WR: begin
                if (addr_q == FILL_START - 12'd1) begin
                    state_d = SCROLL_FILL;
                    we_d    = 1'b1;
                    addr_d  = FILL_START;
                    wdata_d = 8'h20;
                end else begin
                    state_d = SCROLL_RD;
                    addr_d  = addr_q + ROW_BYTES + 12'd1;
                end
            end
            SCROLL_FILL: begin
                if (addr_q == LAST_ADDR) begin
                    go_idle = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = addr_q + 12'd1;
                    wdata_d = blank_byte(addr_d[0]);
                end
            end
            default: state_d = CLEAR;
        endcase

        if (go_scroll) begin
            state_d = SCROLL_RD;
            we_d    = 1'b0;
            addr_d  = ROW_BYTES;
        end else if (go_idle) begin
            state_d = IDLE;
        end
    end

    // Cursor tracks the next row/col so it updates on the same edge.
    always_comb begin
        cursor_d = 11'(row_d) * 11'(COLS) + 11'(col_d);
    end

    // State and output registers; reset restarts with a full screen clear.
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CLEAR;
            col_q    <= 7'd0;
            row_q    <= 5'd0;
            cursor_q <= 11'd0;
            addr_q   <= 12'd0;
            wdata_q  <= 8'd0;
            we_q     <= 1'b0;
            char_q   <= 8'd0;
            attr_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            cursor_q <= cursor_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            char_q   <= char_d;
            attr_q   <= attr_d;
        end
    end

    assign char_ready  = (state_q == IDLE);
    assign busy        = (state_q == CLEAR) || (state_q == SCROLL_RD) ||
                         (state_q == SCROLL_WR) || (state_q == SCROLL_FILL);
    assign mem_we      = we_q;
    assign mem_address = addr_q;
    // During a scroll copy the byte just read goes straight back out.
    assign mem_wdata   = (state_q == SCROLL_WR) ? mem_rdata : wdata_q;
    assign cursor      = cursor_q;

endmodule

// File: tb/tb_cga_tty.sv
// Bench for cga_tty: a videoram model, a screen-level reference model and a
// scoreboard queue checked by a monitor at each completed transaction.
module tb_cga_tty;

    logic        clock_25 = 1'b0;
    logic        reset_n = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'd0;
    logic [7:0]  char_attr = 8'd0;
    logic        char_ready;
    logic [11:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata = 8'd0;
    logic [10:0] cursor;
    logic        busy;

    cga_tty dut (
        .clock_25(clock_25), .reset_n(reset_n),
        .char_valid(char_valid), .char_data(char_data), .char_attr(char_attr),
        .char_ready(char_ready), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .cursor(cursor), .busy(busy)
    );

    always #20 clock_25 = ~clock_25;

    // Videoram: synchronous write, registered read.
    logic [7:0] vram [0:4095];
    always @(posedge clock_25) begin
        if (mem_we) vram[mem_address] <= mem_wdata;
        mem_rdata <= vram[mem_address];
    end

    typedef struct {
        int          cur;
        int          cycles;
        int          busy_cycles;
        int unsigned hash;
        int          tag;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int we_idle_viol = 0;
    int txn_no = 0;

    // Reference model: the screen as a byte array plus row/col.
    logic [7:0] ref_mem [0:3999];
    int ref_col, ref_row;

    function automatic int unsigned hash_mem(input bit use_dut);
        int unsigned h = 32'h811c9dc5;
        for (int i = 0; i < 4000; i++)
            h = (h ^ 32'(use_dut ? vram[i] : ref_mem[i])) * 32'h01000193;
        return h;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4000; i++) ref_mem[i] = (i % 2 == 1) ? 8'h07 : 8'h20;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < 3840; i++) ref_mem[i] = ref_mem[i + 160];
        for (int i = 3840; i < 4000; i++) ref_mem[i] = (i % 2 == 1) ? 8'h07 : 8'h20;
    endtask

    task automatic model_newline(inout int extra, inout int bsy);
        if (ref_row == 24) begin
            model_scroll();
            extra += 7840;
            bsy = 7840;
        end else begin
            ref_row++;
        end
    endtask

    // Update the model, push the expectation, then drive the byte until taken.
    task automatic send(input logic [7:0] c, input logic [7:0] a);
        exp_t e;
        int extra = 0;
        int bsy = 0;
        int base = 2;
        case (c)
            8'h0D: ref_col = 0;
            8'h0A: model_newline(extra, bsy);
            8'h08: if (ref_col > 0) ref_col--;
            8'h0C: begin
                ref_col = 0; ref_row = 0; model_clear();
                base = 4001; bsy = 4000;
            end
`ifdef CGA_TTY_TAB_EN
            8'h09: begin
                if ((ref_col / 8 + 1) * 8 >= 80) begin
                    ref_col = 0;
                    model_newline(extra, bsy);
                end else begin
                    ref_col = (ref_col / 8 + 1) * 8;
                end
            end
`endif
            default: begin
                base = 3;
                ref_mem[2 * (ref_row * 80 + ref_col)]     = c;
                ref_mem[2 * (ref_row * 80 + ref_col) + 1] = a;
                ref_col++;
                if (ref_col == 80) begin
                    ref_col = 0;
                    model_newline(extra, bsy);
                end
            end
        endcase
        e.cur = ref_row * 80 + ref_col;
        e.cycles = base + extra;
        e.busy_cycles = bsy;
        e.hash = hash_mem(1'b0);
        e.tag = int'(c);
        exp_q.push_back(e);

        char_valid = 1'b1;
        char_data  = c;
        char_attr  = a;
        begin : wait_ready
            for (int i = 0; i < 20000; i++) begin
                @(negedge clock_25);
                if (char_ready) disable wait_ready;
            end
            $display("[TB] FAIL ready_timeout: got 0 expected 1");
            fails++;
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "ready never returned");
        end
        @(posedge clock_25);
        #1;
        char_valid = 1'b0;
    endtask

    // Monitor: measures each transaction from acceptance to ready returning.
    logic       in_txn = 1'b0;
    logic       rst_pending = 1'b0;
    int         cyc = 0;
    int         bcnt = 0;
    logic [7:0] cur_byte = 8'd0;

    always @(negedge clock_25) begin
        if (mem_we && char_ready) we_idle_viol++;
        if (in_txn) begin
            cyc++;
            if (busy) bcnt++;
            if (char_ready || cyc > 9000) begin
                in_txn = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("expectation_present", 0, 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ready_back", longint'(char_ready), 1);
                    chk("cursor", longint'(cursor), e.cur);
                    chk("cycles", cyc, e.cycles);
                    chk("busy_cycles", bcnt, e.busy_cycles);
                    chk("vram_hash", longint'(hash_mem(1'b1)), longint'(e.hash));
                    $display("[TB] txn %0d byte %02h cursor %0d cycles %0d busy %0d",
                             txn_no, e.tag, cursor, cyc, bcnt);
                    txn_no++;
                end
            end
        end
        if (!in_txn && reset_n && (rst_pending || (char_valid && char_ready))) begin
            in_txn = 1'b1;
            rst_pending = 1'b0;
            cyc = 0;
            bcnt = 0;
            cur_byte = char_data;
        end
    end

    initial begin
        exp_t e;
        repeat (3) @(posedge clock_25);
        #1;
        chk("reset_cursor", longint'(cursor), 0);
        chk("reset_we", longint'(mem_we), 0);
        chk("reset_addr", longint'(mem_address), 0);
        chk("reset_wdata", longint'(mem_wdata), 0);
        chk("reset_ready", longint'(char_ready), 0);
        chk("reset_busy", longint'(busy), 1);

        ref_col = 0; ref_row = 0; model_clear();
        e.cur = 0; e.cycles = 4001; e.busy_cycles = 4000;
        e.hash = hash_mem(1'b0); e.tag = 8'hFF;
        exp_q.push_back(e);
        rst_pending = 1'b1;
        reset_n = 1'b1;

        // Single character with attribute.
        send(8'h41, 8'h1E);
        // Fill row 0, then one more on row 1.
        send(8'h0D, 8'h00);
        for (int i = 0; i < 80; i++) send(8'h78, 8'h07);
        send(8'h79, 8'h07);
        // Backspace, backspace at column 0, marker at row 1 col 0.
        send(8'h08, 8'h00);
        send(8'h08, 8'h00);
        send(8'h5A, 8'h4F);
        send(8'h0D, 8'h00);
        for (int i = 0; i < 23; i++) send(8'h0A, 8'h00);
        send(8'h61, 8'h07);
        send(8'h62, 8'h07);
        send(8'h0A, 8'h00);           // scroll with col kept at 2
        send(8'h63, 8'h07);
        send(8'h64, 8'h07);
        send(8'h0D, 8'h00);           // CR mid-row
        send(8'h0C, 8'h00);           // form feed
        send(8'h65, 8'h07);
        send(8'h66, 8'h07);
        send(8'h67, 8'h07);
        send(8'h09, 8'h2A);           // tab at col 3
        send(8'h0D, 8'h00);
        send(8'h0A, 8'h00);
        for (int i = 0; i < 75; i++) send(8'h6B, 8'h07);
        send(8'h09, 8'h2A);           // tab near end of row
        for (int i = 0; i < 18; i++) send(8'h0A, 8'h00);

        // Randomised traffic.
        for (int n = 0; n < 80; n++) begin
            int r;
            logic [7:0] c;
            r = $urandom_range(0, 99);
            if (r < 4)       c = 8'h0A;
            else if (r < 8)  c = 8'h0D;
            else if (r < 11) c = 8'h08;
            else if (r < 13) c = 8'h09;
            else             c = 8'($urandom_range(32, 126));
            send(c, 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) @(posedge clock_25);
            #1;
        end

        for (int i = 0; i < 20000 && (exp_q.size() != 0 || in_txn); i++)
            @(negedge clock_25);
        chk("queue_drained", exp_q.size(), 0);
        chk("we_in_idle", we_idle_viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
